// File: rtl/bcd_down_counter_999.sv
// Three-digit BCD down-counter (999..000) with a clamped BCD preset load,
// a terminal-count pulse, and optional wrap from 000 to 999.
// Digits are packed {hundreds, tens, ones}, 4 bits each.
module bcd_down_counter_999 #(
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,     // asynchronous, active-low
  input  logic        enable,
  input  logic        load,
  input  logic [11:0] load_val,
  output logic [11:0] Q,
  output logic        zero,
  output logic        done,
  output logic        borrow,
  output logic        load_err
);

  localparam int NDIG = 3;

  logic [11:0]     q_q, q_d;
  logic            done_q, done_d;
  logic            borrow_q, borrow_d;
  logic            load_err_q, load_err_d;

  logic [11:0]     load_clamped;
  logic [NDIG-1:0] nibble_over;
  logic [11:0]     q_dec;
  logic            q_is_zero;

  // Clamp each preset nibble into 0..9 so the count can never hold a non-BCD digit.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_clamp
      assign nibble_over[gi]          = (load_val[gi*4 +: 4] > 4'd9);
      assign load_clamped[gi*4 +: 4]  = nibble_over[gi] ? 4'd9 : load_val[gi*4 +: 4];
    end
  endgenerate

  assign q_is_zero = (q_q == 12'h000);

  // Ripple-borrow decrement: a digit borrows only when every lower digit was 0.
  always_comb begin
    logic brw;
    q_dec = q_q;
    brw   = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (brw) begin
        if (q_q[i*4 +: 4] == 4'd0) begin
          q_dec[i*4 +: 4] = 4'd9;
        end else begin
          q_dec[i*4 +: 4] = q_q[i*4 +: 4] - 4'd1;
          brw             = 1'b0;
        end
      end
    end
  end

  // Next-state selection: load beats enable beats hold; pulses default low.
  always_comb begin
    q_d        = q_q;
    done_d     = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      q_d        = load_clamped;
      load_err_d = |nibble_over;
    end else if (enable) begin
      if (q_is_zero) begin
        if (WRAP) begin
          q_d      = 12'h999;
          borrow_d = 1'b1;
        end
      end else begin
        q_d    = q_dec;
        done_d = (q_q == 12'h001);
      end
    end
  end

  // All state, including the one-cycle pulse flags, in one register block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q        <= 12'h000;
      done_q     <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      done_q     <= done_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign zero     = q_is_zero;
  assign done     = done_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter_999.sv
// Scoreboard bench: the driver queues hand-computed expectations per clock
// edge; a monitor pops and compares them just after each rising edge.
module tb_bcd_down_counter_999;

  logic        clk = 1'b0;
  logic        reset;
  // wrapping instance (WRAP=1)
  logic        w_en, w_ld;
  logic [11:0] w_val, w_q;
  logic        w_zero, w_done, w_borrow, w_err;
  // holding instance (WRAP=0)
  logic        n_en, n_ld;
  logic [11:0] n_val, n_q;
  logic        n_zero, n_done, n_borrow, n_err;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit          sel;    // 0 = wrapping instance, 1 = holding instance
    logic [11:0] q;
    bit          done;
    bit          borrow;
    bit          err;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bcd_down_counter_999 #(.WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enable(w_en), .load(w_ld), .load_val(w_val),
    .Q(w_q), .zero(w_zero), .done(w_done), .borrow(w_borrow), .load_err(w_err)
  );

  bcd_down_counter_999 #(.WRAP(1'b0)) u_hold (
    .clk(clk), .reset(reset), .enable(n_en), .load(n_ld), .load_val(n_val),
    .Q(n_q), .zero(n_zero), .done(n_done), .borrow(n_borrow), .load_err(n_err)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %03h expected %03h", name, act, expv);
    end
  endtask

  // Monitor: one popped expectation per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [11:0] q;
      logic        z, d, b, le;
      e  = exp_q.pop_front();
      q  = e.sel ? n_q      : w_q;
      z  = e.sel ? n_zero   : w_zero;
      d  = e.sel ? n_done   : w_done;
      b  = e.sel ? n_borrow : w_borrow;
      le = e.sel ? n_err    : w_err;
      chk({e.name, ".Q"},        q,           e.q);
      chk({e.name, ".zero"},     {11'b0, z},  {11'b0, (e.q == 12'h000)});
      chk({e.name, ".done"},     {11'b0, d},  {11'b0, e.done});
      chk({e.name, ".borrow"},   {11'b0, b},  {11'b0, e.borrow});
      chk({e.name, ".load_err"}, {11'b0, le}, {11'b0, e.err});
      $display("txn %-14s sel=%0d Q=%03h zero=%0b done=%0b borrow=%0b load_err=%0b",
               e.name, e.sel, q, z, d, b, le);
    end
  end

  // Drive one clock edge worth of inputs to the selected instance and queue the expectation.
  task automatic step(input bit sel, input bit en, input bit ld, input logic [11:0] val,
                      input logic [11:0] eq, input bit ed, input bit eb, input bit ee,
                      input string name);
    exp_t e;
    @(negedge clk);
    w_en = 1'b0; w_ld = 1'b0; w_val = 12'h000;
    n_en = 1'b0; n_ld = 1'b0; n_val = 12'h000;
    if (sel) begin n_en = en; n_ld = ld; n_val = val; end
    else     begin w_en = en; w_ld = ld; w_val = val; end
    e.sel = sel; e.q = eq; e.done = ed; e.borrow = eb; e.err = ee; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".Q"},        w_q,               12'h000);
    chk({name, ".zero"},     {11'b0, w_zero},   12'h001);
    chk({name, ".done"},     {11'b0, w_done},   12'h000);
    chk({name, ".borrow"},   {11'b0, w_borrow}, 12'h000);
    chk({name, ".load_err"}, {11'b0, w_err},    12'h000);
    $display("txn %-14s Q=%03h zero=%0b done=%0b borrow=%0b load_err=%0b",
             name, w_q, w_zero, w_done, w_borrow, w_err);
  endtask

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    w_en = 1'b0; w_ld = 1'b0; w_val = 12'h000;
    n_en = 1'b0; n_ld = 1'b0; n_val = 12'h000;
    #2;
    chk_reset_state("rst_init");
    chk("rst_init.hold_Q", n_q, 12'h000);
    @(negedge clk);
    reset = 1'b1;

    // 1: borrow across two digits
    step(0, 0, 1, 12'h100, 12'h100, 0, 0, 0, "t1_load100");
    step(0, 1, 0, 12'h000, 12'h099, 0, 0, 0, "t1_dec1");
    step(0, 1, 0, 12'h000, 12'h098, 0, 0, 0, "t1_dec2");
    // 2: terminal count then wrap
    step(0, 0, 1, 12'h002, 12'h002, 0, 0, 0, "t2_load002");
    step(0, 1, 0, 12'h000, 12'h001, 0, 0, 0, "t2_dec1");
    step(0, 1, 0, 12'h000, 12'h000, 1, 0, 0, "t2_done");
    step(0, 1, 0, 12'h000, 12'h999, 0, 1, 0, "t2_wrap");
    step(0, 1, 0, 12'h000, 12'h998, 0, 0, 0, "t2_after");
    step(0, 0, 0, 12'h000, 12'h998, 0, 0, 0, "t2_hold");
    // 3: non-wrapping instance holds at 000
    step(1, 0, 1, 12'h001, 12'h001, 0, 0, 0, "t3_load001");
    step(1, 1, 0, 12'h000, 12'h000, 1, 0, 0, "t3_done");
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 12'h000, 12'h000, 0, 0, 0, "t3_hold0");
    // 4: clamp on load
    step(0, 0, 1, 12'hA5F, 12'h959, 0, 0, 1, "t4_loadA5F");
    step(0, 0, 0, 12'h000, 12'h959, 0, 0, 0, "t4_errclear");
    step(0, 0, 1, 12'h9A0, 12'h990, 0, 0, 1, "t4_load9A0");
    step(0, 0, 1, 12'h123, 12'h123, 0, 0, 0, "t4_load123");
    step(0, 1, 0, 12'h000, 12'h122, 0, 0, 0, "t4_dec");
    // 5: load wins over enable
    step(0, 0, 1, 12'h050, 12'h050, 0, 0, 0, "t5_load050");
    step(0, 1, 1, 12'h777, 12'h777, 0, 0, 0, "t5_loadwins");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 12'h000, 12'h777, 0, 0, 0, "t5_hold");
    step(0, 0, 1, 12'h001, 12'h001, 0, 0, 0, "t5_load001");
    step(0, 1, 1, 12'h000, 12'h000, 0, 0, 0, "t5_ld_nodone");
    step(0, 1, 0, 12'h000, 12'h999, 0, 1, 0, "t5_wrap");
    step(0, 1, 1, 12'h010, 12'h010, 0, 0, 0, "t5_ld_noborrow");
    step(0, 1, 0, 12'h000, 12'h009, 0, 0, 0, "t5_dec010");
    // 6: asynchronous reset mid-cycle while counting
    step(0, 0, 1, 12'h345, 12'h345, 0, 0, 0, "t6_load345");
    step(0, 1, 0, 12'h000, 12'h344, 0, 0, 0, "t6_dec");
    @(negedge clk);
    w_en = 1'b1; w_ld = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("t6_async_rst");
    @(posedge clk);
    #1;
    chk_reset_state("t6_rst_held");
    @(negedge clk);
    w_en = 1'b0;
    reset = 1'b1;
    step(0, 1, 0, 12'h000, 12'h999, 0, 1, 0, "t6_wrap");
    step(0, 0, 0, 12'h000, 12'h999, 0, 0, 0, "t6_hold");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
